// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter: one owner holds the sink for a whole packet,
// output goes through a single register slice, and a beat watchdog caps packet length.
module stream_rr_arbiter #(
  parameter int N         = 4,
  parameter int LEN       = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     s_valid,
  input  logic [N*LEN-1:0] s_data,
  input  logic [N-1:0]     s_last,
  output logic [N-1:0]     s_ready,
  output logic             m_valid,
  output logic [LEN-1:0]   m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic [N-1:0]     grant,
  output logic             busy,
  output logic             trunc
);

  localparam int          PW        = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [N-1:0]     grant_r, grant_s;
  logic             busy_r, busy_s;
  logic [PW-1:0]    ptr_r, ptr_s;
  logic [15:0]      beats_r, beats_s;
  logic             m_valid_r, m_valid_s;
  logic [LEN-1:0]   m_data_r, m_data_s;
  logic             m_last_r, m_last_s;
  logic             trunc_r, trunc_s;

  logic [N-1:0]     ready_s;
  logic             xfer_s;
  logic             release_s;
  logic [PW-1:0]    g_idx_s;
  logic [LEN-1:0]   g_data_s;
  logic             g_last_s;
  logic             found_s;
  logic [PW-1:0]    pick_s;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    sum = (sum >= N) ? (sum - N) : sum;
    return PW'(sum);
  endfunction

  // Owner mux: grant is one-hot, so OR-reduction selects the owner's beat.
  always_comb begin
    g_idx_s  = {PW{1'b0}};
    g_data_s = {LEN{1'b0}};
    g_last_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      g_idx_s  = g_idx_s  | (PW'(i) & {PW{grant_r[i]}});
      g_data_s = g_data_s | (s_data[i*LEN +: LEN] & {LEN{grant_r[i]}});
      g_last_s = g_last_s | (s_last[i] & grant_r[i]);
    end
  end

  // Source accept and release decode.
  always_comb begin
    ready_s   = grant_r & {N{busy_r && (!m_valid_r || m_ready)}};
    xfer_s    = |(ready_s & s_valid);
    release_s = xfer_s && (g_last_s || (beats_r == LAST_BEAT));
  end

  // Round-robin scan from ptr; descending loop lets the nearest candidate win.
  always_comb begin
    found_s = 1'b0;
    pick_s  = ptr_r;
    for (int k = N - 1; k >= 0; k--) begin
      found_s = found_s | s_valid[wrap_idx(ptr_r, k)];
      pick_s  = s_valid[wrap_idx(ptr_r, k)] ? wrap_idx(ptr_r, k) : pick_s;
    end
  end

  // FSM next state and output-slice next values.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    busy_s    = busy_r;
    ptr_s     = ptr_r;
    beats_s   = beats_r;
    m_valid_s = m_valid_r;
    m_data_s  = m_data_r;
    m_last_s  = m_last_r;
    trunc_s   = 1'b0;

    if (xfer_s) begin
      m_valid_s = 1'b1;
      m_data_s  = g_data_s;
      m_last_s  = release_s;
    end else if (m_valid_r && m_ready) begin
      m_valid_s = 1'b0;
    end else begin
      m_valid_s = m_valid_r;
    end

    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = LOCK;
          grant_s = {{(N-1){1'b0}}, 1'b1} << pick_s;
          busy_s  = 1'b1;
          beats_s = 16'd0;
        end else begin
          state_s = IDLE;
        end
      end
      LOCK: begin
        if (release_s) begin
          state_s = IDLE;
          grant_s = {N{1'b0}};
          busy_s  = 1'b0;
          ptr_s   = wrap_idx(g_idx_s, 1);
          beats_s = 16'd0;
          trunc_s = !g_last_s;
        end else if (xfer_s) begin
          beats_s = beats_r + 16'd1;
        end else begin
          state_s = LOCK;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = {N{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      grant_r   <= {N{1'b0}};
      busy_r    <= 1'b0;
      ptr_r     <= {PW{1'b0}};
      beats_r   <= 16'd0;
      m_valid_r <= 1'b0;
      m_data_r  <= {LEN{1'b0}};
      m_last_r  <= 1'b0;
      trunc_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      busy_r    <= busy_s;
      ptr_r     <= ptr_s;
      beats_r   <= beats_s;
      m_valid_r <= m_valid_s;
      m_data_r  <= m_data_s;
      m_last_r  <= m_last_s;
      trunc_r   <= trunc_s;
    end
  end

  assign s_ready = ready_s;
  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign m_last  = m_last_r;
  assign grant   = grant_r;
  assign busy    = busy_r;
  assign trunc   = trunc_r;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: cycle vector table plus
// queue-driven sequences for contention, random backpressure, watchdog and reset.
module tb_stream_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_valid;
  logic [31:0] s_data;
  logic [3:0]  s_last;
  logic [3:0]  s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready;
  logic [3:0]  grant;
  logic        busy;
  logic        trunc;

  stream_rr_arbiter #(.N(4), .LEN(8), .MAX_BEATS(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .grant(grant), .busy(busy), .trunc(trunc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        rst_first;
    logic [3:0]  sv;
    logic [31:0] sd;
    logic [3:0]  sl;
    logic        mr;
    logic        mv;
    logic [7:0]  md;
    logic        ml;
    logic [3:0]  gr;
    logic        bz;
    logic [3:0]  sr;
  } vec_t;

  vec_t vt [0:21];

  // Source stimulus {last, data} and expected output {m_last, data} per source.
  logic [8:0] src_q [4][$];
  logic [8:0] exp_q [4][$];
  logic [1:0] out_src [$];
  int         seq [4];
  int         trunc_cnt;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < 4; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      seq[i] = 0;
    end
    out_src.delete();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    s_valid = 4'b0; s_last = 4'b0; s_data = 32'h0; m_ready = 1'b0;
    clear_queues();
    prev_stall = 1'b0;
    trunc_cnt = 0;
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_trunc", trunc, 1'b0);
    chk("rst_s_ready", s_ready, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic push(input int src, input logic [5:0] sq, input logic last, input logic elast);
    src_q[src].push_back({last, 2'(src), sq});
    exp_q[src].push_back({elast, 2'(src), sq});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < 4; i++)
      if (exp_q[i].size() != 0 || src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One cycle per iteration: drive heads of source queues, score the sink side.
  task automatic run_cycles(input int n, input bit rnd);
    logic [8:0] h;
    logic [8:0] e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (src_q[i].size() > 0) begin
          h = src_q[i][0];
          s_valid[i] = 1'b1;
          s_data[i*8 +: 8] = h[7:0];
          s_last[i] = h[8];
        end else begin
          s_valid[i] = 1'b0;
          s_last[i] = 1'b0;
        end
      end
      #1;
      if (prev_stall) chk("stall_stable", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      chk("sready_onehot", 32'($onehot0(s_ready)), 32'd1);
      chk("sready_in_grant", s_ready & ~grant, 4'b0000);
      if (trunc) begin
        trunc_cnt++;
        chk("trunc_align", {m_valid, m_last, m_data}, {1'b1, 1'b1, 8'h10});
      end
      if (m_valid && m_ready) begin
        out_src.push_back(m_data[7:6]);
        if (exp_q[m_data[7:6]].size() == 0) begin
          chk("unexpected_beat", {m_last, m_data}, 9'h1FF);
        end else begin
          e = exp_q[m_data[7:6]].pop_front();
          chk("out_beat", {m_last, m_data}, e);
        end
      end
      for (int i = 0; i < 4; i++)
        if (s_valid[i] && s_ready[i]) void'(src_q[i].pop_front());
    end
  endtask

  task automatic drain(input string nm, input bit rnd, input int budget);
    int guard;
    guard = 0;
    while (!all_empty() && guard < budget) begin
      run_cycles(1, rnd);
      guard++;
    end
    chk(nm, 32'(all_empty()), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    s_valid = 4'b0; s_data = 32'h0; s_last = 4'b0; m_ready = 1'b0;
    prev_stall = 1'b0;
    trunc_cnt = 0;

    // Single source 3-beat packet.
    vt[0]  = '{1'b1, 4'b0001, 32'h00000011, 4'b0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 4'b0000};
    vt[1]  = '{1'b0, 4'b0001, 32'h00000011, 4'b0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0001, 1'b1, 4'b0001};
    vt[2]  = '{1'b0, 4'b0001, 32'h00000022, 4'b0000, 1'b1, 1'b1, 8'h11, 1'b0, 4'b0001, 1'b1, 4'b0001};
    vt[3]  = '{1'b0, 4'b0001, 32'h00000033, 4'b0001, 1'b1, 1'b1, 8'h22, 1'b0, 4'b0001, 1'b1, 4'b0001};
    vt[4]  = '{1'b0, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b1, 8'h33, 1'b1, 4'b0000, 1'b0, 4'b0000};
    vt[5]  = '{1'b0, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 4'b0000};
    // Four sources with continuous 1-beat packets, then backpressure.
    vt[6]  = '{1'b1, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 4'b0000};
    vt[7]  = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0001, 1'b1, 4'b0001};
    vt[8]  = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b1, 8'hA0, 1'b1, 4'b0000, 1'b0, 4'b0000};
    vt[9]  = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0010, 1'b1, 4'b0010};
    vt[10] = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b1, 8'hA1, 1'b1, 4'b0000, 1'b0, 4'b0000};
    vt[11] = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0100, 1'b1, 4'b0100};
    vt[12] = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b1, 8'hA2, 1'b1, 4'b0000, 1'b0, 4'b0000};
    vt[13] = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b0, 8'h00, 1'b0, 4'b1000, 1'b1, 4'b1000};
    vt[14] = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b1, 8'hA3, 1'b1, 4'b0000, 1'b0, 4'b0000};
    vt[15] = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0001, 1'b1, 4'b0001};
    vt[16] = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b1, 8'hA0, 1'b1, 4'b0000, 1'b0, 4'b0000};
    vt[17] = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0010, 1'b1, 4'b0010};
    vt[18] = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b0, 1'b1, 8'hA1, 1'b1, 4'b0000, 1'b0, 4'b0000};
    vt[19] = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b0, 1'b1, 8'hA1, 1'b1, 4'b0100, 1'b1, 4'b0000};
    vt[20] = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b1, 8'hA1, 1'b1, 4'b0100, 1'b1, 4'b0100};
    vt[21] = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b1, 8'hA2, 1'b1, 4'b0000, 1'b0, 4'b0000};

    for (int r = 0; r < 22; r++) begin
      if (vt[r].rst_first) reset_dut();
      @(negedge clk);
      s_valid = vt[r].sv; s_data = vt[r].sd; s_last = vt[r].sl; m_ready = vt[r].mr;
      #1;
      chk($sformatf("row%0d_m_valid", r), m_valid, vt[r].mv);
      if (vt[r].mv) begin
        chk($sformatf("row%0d_m_data", r), m_data, vt[r].md);
        chk($sformatf("row%0d_m_last", r), m_last, vt[r].ml);
      end
      chk($sformatf("row%0d_grant", r), grant, vt[r].gr);
      chk($sformatf("row%0d_busy", r), busy, vt[r].bz);
      chk($sformatf("row%0d_s_ready", r), s_ready, vt[r].sr);
      chk($sformatf("row%0d_trunc", r), trunc, 1'b0);
    end

    // Source 2 packet holds the grant while 1 and 3 request mid-packet.
    reset_dut();
    for (int k = 0; k < 4; k++) push(2, 6'(k), k == 3, k == 3);
    run_cycles(2, 1'b0);
    push(1, 6'd0, 1'b0, 1'b0);
    push(1, 6'd1, 1'b1, 1'b1);
    push(3, 6'd0, 1'b1, 1'b1);
    drain("contend_drain", 1'b0, 100);
    chk("contend_count", out_src.size(), 7);
    for (int k = 0; k < 7 && k < out_src.size(); k++)
      chk($sformatf("contend_order%0d", k), out_src[k], (k < 4) ? 2'd2 : ((k == 4) ? 2'd3 : 2'd1));

    // 200 packets under 50% random backpressure.
    reset_dut();
    for (int p = 0; p < 200; p++) begin
      int src;
      int len;
      src = p % 4;
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        push(src, 6'(seq[src]), b == len - 1, b == len - 1);
        seq[src]++;
      end
    end
    drain("random_drain", 1'b1, 20000);
    chk("random_no_trunc", trunc_cnt, 0);

    // 20-beat packet forced into 16 + 4 by the watchdog.
    reset_dut();
    for (int k = 1; k <= 20; k++) push(0, 6'(k), k == 20, (k == 16) || (k == 20));
    drain("wd_drain", 1'b0, 200);
    run_cycles(2, 1'b0);
    chk("wd_trunc_count", trunc_cnt, 1);

    // Asynchronous reset with beat 2 of a 5-beat packet in the slice.
    reset_dut();
    for (int k = 1; k <= 5; k++) push(0, 6'(k), k == 5, k == 5);
    run_cycles(3, 1'b0);
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    chk("pre_rst_m_valid", m_valid, 1'b1);
    chk("pre_rst_m_data", m_data, 8'h02);
    #1;
    rst = 1'b0;
    #1;
    chk("async_m_valid", m_valid, 1'b0);
    chk("async_grant", grant, 4'b0000);
    chk("async_busy", busy, 1'b0);
    chk("async_s_ready", s_ready, 4'b0000);
    clear_queues();
    s_valid = 4'b1010; s_data = 32'h55004400; s_last = 4'b1010; m_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_grant", grant, 4'b0010);
    chk("post_rst_busy", busy, 1'b1);
    @(negedge clk);
    s_valid = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
